// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit.
//   DATA_WIDTH_32    : width of addresses and instruction words
//   INSTR_BYTES      : fetch address increment per instruction
//   DEFAULT_RESET_PC : default fetch address after reset
//   cnt_w(depth)     : width of an occupancy counter that can hold 0..depth
package instr_fetch_unit_pkg;

    localparam int                 DATA_WIDTH_32    = 32;
    localparam logic [31:0]        INSTR_BYTES      = 32'd4;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// fetch_buffer: small synchronous FIFO with flush and occupancy count.
// Used both as the pending-PC queue (one entry per in-flight request) and
// as the instruction FIFO toward decode.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears storage too)
//   flush    : drop all entries this cycle (overrides push/pop)
//   push     : write wdata at the tail
//   pop      : advance the head (ignored when empty)
//   rdata    : head entry, read straight from storage (registered data)
//   count    : number of valid entries, 0..DEPTH
module fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

    // Upstream credit accounting must never let the FIFO overflow.
    overflow_check: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues in-order imem requests
// (req/gnt/rvalid), buffers returned words with their PC and hands them to
// decode over valid/ready. A redirect flushes buffered words and marks all
// in-flight responses for discard.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and
// stops fetching after a redirect to a non-word-aligned target.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc  : load a new fetch address (highest priority)
//   imem_req, imem_addr          : request to instruction memory
//   imem_gnt                     : request accepted when imem_req & imem_gnt
//   imem_rvalid, imem_rdata      : in-order response
//   instr_valid, instr_ready     : decode handshake
//   instr_data, instr_pc         : head instruction and its address
//   fetch_misaligned (optional)  : sticky misaligned-redirect flag
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [DATA_WIDTH_32-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                       DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [DATA_WIDTH_32-1:0] redirect_pc,
    output logic                     imem_req,
    output logic [DATA_WIDTH_32-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH_32-1:0] imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH_32-1:0] instr_data,
    output logic [DATA_WIDTH_32-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                     fetch_misaligned
`endif
);

    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH_32-1:0] fetch_pc;
    logic [DATA_WIDTH_32-1:0] pend_pc;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            discard;
    logic [CW:0]              credit_used;
    logic                     grant;
    logic                     drop;
    logic                     pop;
    logic                     misaligned;

    assign grant       = imem_req & imem_gnt;
    // A response is dropped if it belongs to a flushed stream, including one
    // that arrives in the redirect cycle itself.
    assign drop        = redirect_valid | (discard != '0);
    // Credit covers in-flight requests (discarded ones too) plus buffered words.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req    = !rst && !redirect_valid && !misaligned &&
                         (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign instr_valid = !rst && !redirect_valid && (fifo_count != '0);
    assign pop         = instr_valid & instr_ready;

    // Pending-PC queue: its occupancy is the in-flight request count.
    fetch_buffer #(.WIDTH(DATA_WIDTH_32), .DEPTH(DEPTH)) u_pend_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (grant),
        .wdata (fetch_pc),
        .pop   (imem_rvalid),
        .rdata (pend_pc),
        .count (outstanding)
    );

    fetch_buffer #(.WIDTH(2*DATA_WIDTH_32), .DEPTH(DEPTH)) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (imem_rvalid & !drop),
        .wdata ({pend_pc, imem_rdata}),
        .pop   (pop),
        .rdata ({instr_pc, instr_data}),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            discard  <= outstanding - CW'(imem_rvalid && (outstanding != '0));
        end else begin
            if (grant) fetch_pc <= fetch_pc + INSTR_BYTES;
            if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                 misaligned <= 1'b0;
        else if (redirect_valid) misaligned <= (redirect_pc[1:0] != 2'b00);
    end
    assign fetch_misaligned = misaligned;
`else
    assign misaligned = 1'b0;
`endif

endmodule
